// File: rtl/mem_access_unit.sv
// Request/response front end for a single-port word memory: loads one or two words, stores one word,
// and rejects illegal requests with an error response and a saturating error counter.
module mem_access_unit #(
  parameter int N = 2097152
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_op,
  input  logic [31:0]        req_addr1,
  input  logic [31:0]        req_addr2,
  input  logic [31:0]        req_wdata,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic signed [31:0] resp_data1,
  output logic signed [31:0] resp_data2,
  output logic               resp_err,
  output logic [7:0]         err_count,
  output logic [31:0]        mem_address1,
  output logic [31:0]        mem_address2,
  output logic [31:0]        mem_write_data,
  output logic               mem_EN,
  output logic [1:0]         mem_read,
  output logic               mem_write,
  input  logic [31:0]        mem_data1,
  input  logic [31:0]        mem_data2
);

  localparam logic [31:0] HALF = 32'(N / 2);
  localparam logic [1:0] OP_LOAD1 = 2'b00;
  localparam logic [1:0] OP_LOAD2 = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state, next_state;
  logic        pending;
  logic [1:0]  op_q;
  logic [31:0] addr1_q, addr2_q, wdata_q;
  logic        accept, rejected;

  assign accept   = req_valid && req_ready;
  assign rejected = (op_q == OP_RSVD) || (addr1_q >= HALF) ||
                    ((op_q == OP_LOAD2) && (addr2_q >= HALF));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // An accepted request spends one cycle in IDLE with pending set so it can be decoded from the registered copy.
  always_comb begin
    next_state     = state;
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    mem_EN         = 1'b0;
    mem_read       = 2'd0;
    mem_write      = 1'b0;
    mem_address1   = 32'd0;
    mem_address2   = 32'd0;
    mem_write_data = 32'd0;
    case (state)
      IDLE: begin
        req_ready = !pending;
        if (pending) next_state = rejected ? RESP : ISSUE;
      end
      ISSUE: begin
        mem_EN         = 1'b1;
        mem_address1   = addr1_q;
        mem_address2   = addr2_q;
        mem_write_data = wdata_q;
        if (op_q == OP_LOAD1)      mem_read = 2'd1;
        else if (op_q == OP_LOAD2) mem_read = 2'd2;
        mem_write  = (op_q == OP_STORE);
        next_state = (op_q == OP_STORE) ? RESP : WAIT;
      end
      WAIT: begin
        mem_EN         = 1'b1;
        mem_address1   = addr1_q;
        mem_address2   = addr2_q;
        mem_write_data = wdata_q;
        next_state     = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending    <= 1'b0;
      op_q       <= 2'd0;
      addr1_q    <= 32'd0;
      addr2_q    <= 32'd0;
      wdata_q    <= 32'd0;
      resp_err   <= 1'b0;
      resp_data1 <= 32'sd0;
      resp_data2 <= 32'sd0;
      err_count  <= 8'd0;
    end else begin
      if (accept) begin
        pending <= 1'b1;
        op_q    <= req_op;
        addr1_q <= req_addr1;
        addr2_q <= req_addr2;
        wdata_q <= req_wdata;
      end
      if (state == IDLE && pending) begin
        pending    <= 1'b0;
        resp_err   <= rejected;
        resp_data1 <= 32'sd0;
        resp_data2 <= 32'sd0;
        if (rejected && err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
      if (state == WAIT) begin
        resp_data1 <= mem_data1;
        resp_data2 <= (op_q == OP_LOAD2) ? mem_data2 : 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit: a registered-read memory model on the port and a
// transaction-level reference (expected memory contents, latency and error count).
module tb_mem_access_unit;

  localparam int          N    = 2097152;
  localparam logic [31:0] HALF = 32'd1048576;

  logic               clk = 1'b0;
  logic               reset;
  logic               req_valid, req_ready;
  logic [1:0]         req_op;
  logic [31:0]        req_addr1, req_addr2, req_wdata;
  logic               resp_valid, resp_ready;
  logic signed [31:0] resp_data1, resp_data2;
  logic               resp_err;
  logic [7:0]         err_count;
  logic [31:0]        mem_address1, mem_address2, mem_write_data;
  logic               mem_EN;
  logic [1:0]         mem_read;
  logic               mem_write;
  logic [31:0]        mem_data1, mem_data2;

  int numCompared = 0;
  int numMismatched = 0;
  logic [31:0] refRam [logic [31:0]];
  int refErr = 0;
  logic [31:0] ram [0:63];

  mem_access_unit #(.N(N)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr1(req_addr1), .req_addr2(req_addr2), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data1(resp_data1), .resp_data2(resp_data2),
    .resp_err(resp_err), .err_count(err_count),
    .mem_address1(mem_address1), .mem_address2(mem_address2),
    .mem_write_data(mem_write_data), .mem_EN(mem_EN),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_data1(mem_data1), .mem_data2(mem_data2)
  );

  always #5 clk = ~clk;

  // Memory with registered read data, indexed by the low address bits (tests keep legal addresses distinct there).
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) ram[i] <= 32'd0;
      mem_data1 <= 32'd0;
      mem_data2 <= 32'd0;
    end else if (mem_EN) begin
      if (mem_write) ram[mem_address1[5:0]] <= mem_write_data;
      if (mem_read == 2'd1 || mem_read == 2'd2) mem_data1 <= ram[mem_address1[5:0]];
      if (mem_read == 2'd2) mem_data2 <= ram[mem_address2[5:0]];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    numCompared++;
    if (obs !== exp) begin
      numMismatched++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] refRead(input logic [31:0] a);
    return refRam.exists(a) ? refRam[a] : 32'd0;
  endfunction

  function automatic logic [31:0] pickAddr();
    case ($urandom_range(0, 5))
      3:       return HALF - 32'd1;
      4:       return HALF + 32'($urandom_range(0, 100));
      5:       return 32'h8000_0000 | 32'($urandom);
      default: return 32'($urandom_range(0, 31));
    endcase
  endfunction

  // Issue one request from an IDLE position just after a falling edge, then follow it to completion.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a1, input logic [31:0] a2,
                               input logic [31:0] wd, input int hold);
    logic rej;
    int expLat, lat, strobes, enCycles, expEn;
    logic [31:0] expD1, expD2, obsA1, obsA2, obsWd, s1, s2;
    logic [1:0] obsCode, expCode;
    logic obsWr, overlap, readyDuring, stable;
    rej     = (op == 2'b11) || (a1 >= HALF) || (op == 2'b01 && a2 >= HALF);
    expLat  = rej ? 1 : (op == 2'b10 ? 2 : 3);
    expD1   = (!rej && op != 2'b10) ? refRead(a1) : 32'd0;
    expD2   = (!rej && op == 2'b01) ? refRead(a2) : 32'd0;
    expEn   = rej ? 0 : (op == 2'b10 ? 1 : 2);
    expCode = rej ? 2'd0 : (op == 2'b00 ? 2'd1 : (op == 2'b01 ? 2'd2 : 2'd0));
    if (!rej && op == 2'b10) refRam[a1] = wd;
    if (rej && refErr < 255) refErr++;

    req_valid = 1'b1; req_op = op; req_addr1 = a1; req_addr2 = a2; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_op = 2'($urandom); req_addr1 = $urandom; req_addr2 = $urandom; req_wdata = $urandom;

    lat = -1; strobes = 0; enCycles = 0; obsCode = 0; obsWr = 0;
    obsA1 = 0; obsA2 = 0; obsWd = 0; overlap = 0; readyDuring = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (req_ready && resp_valid) overlap = 1'b1;
      if (resp_valid) begin lat = c; break; end
      if (req_ready) readyDuring = 1'b1;
      if (mem_EN) enCycles++;
      if (mem_EN && (mem_read != 2'd0 || mem_write)) begin
        strobes++; obsCode = mem_read; obsWr = mem_write;
        obsA1 = mem_address1; obsA2 = mem_address2; obsWd = mem_write_data;
      end
    end
    checkOutput("latency", 32'(lat), 32'(expLat));
    checkOutput("resp_err", 32'(resp_err), 32'(rej));
    checkOutput("resp_data1", resp_data1, expD1);
    checkOutput("resp_data2", resp_data2, expD2);
    checkOutput("err_count", 32'(err_count), 32'(refErr));
    checkOutput("strobes", 32'(strobes), rej ? 32'd0 : 32'd1);
    checkOutput("en_cycles", 32'(enCycles), 32'(expEn));
    checkOutput("mem_read", 32'(obsCode), 32'(expCode));
    checkOutput("mem_write", 32'(obsWr), 32'(!rej && op == 2'b10));
    checkOutput("mem_address1", obsA1, rej ? 32'd0 : a1);
    if (!rej && op == 2'b01) checkOutput("mem_address2", obsA2, a2);
    if (!rej && op == 2'b10) checkOutput("mem_write_data", obsWd, wd);
    checkOutput("ready_valid_overlap", 32'(overlap), 32'd0);
    checkOutput("ready_while_busy", 32'(readyDuring), 32'd0);

    if (hold > 0) begin
      s1 = resp_data1; s2 = resp_data2; stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (!resp_valid || req_ready || resp_data1 !== s1 || resp_data2 !== s2) stable = 1'b0;
      end
      checkOutput("hold_stable", 32'(stable), 32'd1);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    checkOutput("idle_req_ready", 32'(req_ready), 32'd1);
    checkOutput("idle_resp_valid", 32'(resp_valid), 32'd0);
  endtask

  initial begin
    logic quiet;
    reset = 1'b1; req_valid = 1'b0; req_op = 2'd0; req_addr1 = 0; req_addr2 = 0;
    req_wdata = 0; resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rst_resp_err", 32'(resp_err), 32'd0);
    checkOutput("rst_resp_data1", resp_data1, 32'd0);
    checkOutput("rst_resp_data2", resp_data2, 32'd0);
    checkOutput("rst_err_count", 32'(err_count), 32'd0);
    checkOutput("rst_mem_en", {29'd0, mem_EN, mem_read}, 32'd0);
    checkOutput("rst_mem_write", 32'(mem_write), 32'd0);
    checkOutput("rst_mem_addr", mem_address1 | mem_address2 | mem_write_data, 32'd0);

    applyStimulus(2'b00, HALF, 32'd0, 32'd0, 0);
    applyStimulus(2'b10, 32'd5, 32'd0, 32'hDEADBEEF, 0);
    applyStimulus(2'b10, 32'd6, 32'd0, 32'hFFFFFFF9, 0);
    applyStimulus(2'b01, 32'd5, 32'd6, 32'd0, 0);
    applyStimulus(2'b00, 32'd6, 32'd0, 32'd0, 4);
    applyStimulus(2'b01, 32'd5, HALF, 32'd0, 2);

    // Reset while a load-pair sits in WAIT.
    req_valid = 1'b1; req_op = 2'b01; req_addr1 = 32'd5; req_addr2 = 32'd6;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    checkOutput("midrst_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("midrst_mem", {29'd0, mem_EN, mem_read}, 32'd0);
    checkOutput("midrst_addr", mem_address1 | mem_address2, 32'd0);
    checkOutput("midrst_err_count", 32'(err_count), 32'd0);
    refRam.delete();
    refErr = 0;
    @(negedge clk);
    reset = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (resp_valid || mem_EN || !req_ready) quiet = 1'b0;
    end
    checkOutput("midrst_quiet", 32'(quiet), 32'd1);
    applyStimulus(2'b00, 32'd5, 32'd0, 32'd0, 0);

    for (int i = 0; i < 60; i++)
      applyStimulus(2'($urandom), pickAddr(), pickAddr(), $urandom, $urandom_range(0, 2));

    for (int i = 0; i < 300; i++)
      applyStimulus(2'b11, $urandom_range(0, 31), 32'd0, 32'd0, 0);
    checkOutput("err_count_saturated", 32'(err_count), 32'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
